// File: rtl/imm_gen_stage_pkg.sv
// Shared types for the immediate generator stage: immediate-type encoding,
// buffer occupancy states and the XLEN legality check.
package imm_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned SRC_W   = 3;

    typedef enum logic [SRC_W-1:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_J   = 3'b011,
        IMM_U   = 3'b100,
        IMM_Z   = 3'b101,
        IMM_SH  = 3'b110,
        IMM_BAD = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

    function automatic bit xlen_ok(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Decode-to-execute immediate channel: upstream entry request and downstream result.
interface imm_gen_stage_if
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) ();

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    imm_src_e           in_imm_src;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_imm;
    logic [TAG_W-1:0]   out_tag;
    logic               out_illegal;

    modport master (
        output in_valid, in_instr, in_imm_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );

endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate extraction for RV I/S/B/J/U plus CSR zimm and shamt.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    input  imm_src_e           imm_src,
    output logic [XLEN-1:0]    imm_c,
    output logic               illegal_c
);

    localparam int unsigned SH_W = (XLEN == 64) ? 6 : 5;

    // Opcode field is decoded elsewhere.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Size casts of signed fields sign-extend; unsigned fields zero-extend.
    always_comb begin
        imm_c     = '0;
        illegal_c = 1'b0;
        case (imm_src)
            IMM_I:   imm_c = XLEN'($signed(instr[31:20]));
            IMM_S:   imm_c = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:   imm_c = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                             instr[11:8], 1'b0}));
            IMM_J:   imm_c = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                             instr[30:21], 1'b0}));
            IMM_U:   imm_c = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_Z:   imm_c = XLEN'(instr[19:15]);
            IMM_SH:  imm_c = XLEN'(instr[20 +: SH_W]);
            IMM_BAD: illegal_c = 1'b1;
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: decodes at the input, then buffers results in a
// main register plus one skid entry so in_ready never depends on out_ready.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    imm_gen_stage_if.slave   bus
);

    if (!xlen_ok(XLEN)) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm_c;
    logic            dec_illegal_c;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr     (bus.in_instr),
        .imm_src   (bus.in_imm_src),
        .imm_c     (dec_imm_c),
        .illegal_c (dec_illegal_c)
    );

    occ_e             state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [XLEN-1:0]  main_imm_q, main_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             main_ill_q, main_ill_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_ill_q, skid_ill_d;
    logic             accept_c, drain_c;

    // Occupancy FSM; data registers only move on accept or skid-to-main promotion.
    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        main_ill_d = main_ill_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        accept_c   = bus.in_valid && in_ready_q;
        drain_c    = out_valid_q && bus.out_ready;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d    = ST_ONE;
                        main_imm_d = dec_imm_c;
                        main_tag_d = bus.in_tag;
                        main_ill_d = dec_illegal_c;
                    end
                end
                ST_ONE: begin
                    if (accept_c && drain_c) begin
                        main_imm_d = dec_imm_c;
                        main_tag_d = bus.in_tag;
                        main_ill_d = dec_illegal_c;
                    end else if (accept_c) begin
                        state_d    = ST_TWO;
                        skid_imm_d = dec_imm_c;
                        skid_tag_d = bus.in_tag;
                        skid_ill_d = dec_illegal_c;
                    end else if (drain_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain_c) begin
                        state_d    = ST_ONE;
                        main_imm_d = skid_imm_q;
                        main_tag_d = skid_tag_q;
                        main_ill_d = skid_ill_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_imm_q  <= '0;
            main_tag_q  <= '0;
            main_ill_q  <= 1'b0;
            skid_imm_q  <= '0;
            skid_tag_q  <= '0;
            skid_ill_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            main_imm_q  <= main_imm_d;
            main_tag_q  <= main_tag_d;
            main_ill_q  <= main_ill_d;
            skid_imm_q  <= skid_imm_d;
            skid_tag_q  <= skid_tag_d;
            skid_ill_q  <= skid_ill_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = main_imm_q;
    assign bus.out_tag     = main_tag_q;
    assign bus.out_illegal = main_ill_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are checked every cycle against a queue-based reference model.
module tb_imm_gen_stage;
    import imm_pkg::*;

    localparam int unsigned TAG_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_instr;
    logic [2:0]       in_src;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32), .TAG_W(TAG_W)) b32 ();
    imm_gen_stage_if #(.XLEN(64), .TAG_W(TAG_W)) b64 ();

    assign b32.in_valid   = in_valid;
    assign b32.in_instr   = in_instr;
    assign b32.in_imm_src = imm_src_e'(in_src);
    assign b32.in_tag     = in_tag;
    assign b32.out_ready  = out_ready;
    assign b64.in_valid   = in_valid;
    assign b64.in_instr   = in_instr;
    assign b64.in_imm_src = imm_src_e'(in_src);
    assign b64.in_tag     = in_tag;
    assign b64.out_ready  = out_ready;

    imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b32.slave));
    imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b64.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference immediate computed from field arithmetic on a 64-bit signed view.
    function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] s,
                                            input int xlen);
        int     iw;
        longint lw, u, sg, v;
        iw = $signed(w);
        lw = iw;
        u  = longint'({32'b0, w});
        sg = lw >>> 31;
        case (s)
            3'd0:    v = lw >>> 20;
            3'd1:    v = ((lw >>> 20) & -32) | ((u >> 7) & 31);
            3'd2:    v = (sg << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5)
                         | (((u >> 8) & 15) << 1);
            3'd3:    v = (sg << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11)
                         | (((u >> 21) & 1023) << 1);
            3'd4:    v = lw & -4096;
            3'd5:    v = (u >> 15) & 31;
            3'd6:    v = (u >> 20) & ((xlen == 64) ? 63 : 31);
            default: v = 0;
        endcase
        return v;
    endfunction

    typedef struct {
        logic [31:0]      instr;
        logic [2:0]       src;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t q[$];
    bit   data_clean = 1'b1;
    int   accepted   = 0;

    // Model: a FIFO of at most two raw entries; accept whenever fewer than two are held.
    always @(posedge clk) begin
        if (rst || flush) begin
            q.delete();
            if (rst) data_clean = 1'b1;
        end else begin
            bit rdy;
            rdy = (q.size() < 2);
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy) begin
                q.push_back('{instr: in_instr, src: in_src, tag: in_tag});
                data_clean = 1'b0;
                accepted++;
            end
        end
    end

    // Every-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (!rst) begin
            logic [63:0] e32, e64;
            logic        ill;
            chk("out_valid32", 64'(b32.out_valid), 64'(q.size() != 0));
            chk("out_valid64", 64'(b64.out_valid), 64'(q.size() != 0));
            chk("in_ready32",  64'(b32.in_ready),  64'(q.size() < 2));
            chk("in_ready64",  64'(b64.in_ready),  64'(q.size() < 2));
            if (q.size() != 0) begin
                e32 = ref_imm(q[0].instr, q[0].src, 32);
                e64 = ref_imm(q[0].instr, q[0].src, 64);
                ill = (q[0].src == 3'd7);
                chk("imm32", 64'(b32.out_imm), {32'b0, e32[31:0]});
                chk("imm64", b64.out_imm, e64);
                chk("tag32", 64'(b32.out_tag), 64'(q[0].tag));
                chk("tag64", 64'(b64.out_tag), 64'(q[0].tag));
                chk("illegal32", 64'(b32.out_illegal), 64'(ill));
                chk("illegal64", 64'(b64.out_illegal), 64'(ill));
            end else if (data_clean) begin
                chk("idle_imm32", 64'(b32.out_imm), 64'd0);
                chk("idle_imm64", b64.out_imm, 64'd0);
                chk("idle_tag32", 64'(b32.out_tag), 64'd0);
                chk("idle_ill64", 64'(b64.out_illegal), 64'd0);
            end
        end
    end

    bit         cap = 1'b0;
    logic [TAG_W-1:0] emitted[$];
    bit         saw_dead = 1'b0;

    always @(negedge clk) begin
        if (cap && b32.out_valid && out_ready) emitted.push_back(b32.out_tag);
        if ((b32.out_valid && b32.out_tag == 32'hDEAD) ||
            (b64.out_valid && b64.out_tag == 32'hDEAD)) saw_dead = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Offer one entry into an empty stage, then stop at the negedge after acceptance.
    task automatic send1(input logic [31:0] w, input logic [2:0] s, input logic [31:0] t);
        #1;
        in_valid  = 1'b1;
        in_instr  = w;
        in_src    = s;
        in_tag    = t;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lit_valid32", 64'(b32.out_valid), 64'd1);
        chk("lit_tag64", 64'(b64.out_tag), 64'(t));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int  nt;
        bit  r;
        int  guard;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_src = '0;
        in_tag = '0; out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid32", 64'(b32.out_valid), 64'd0);
        chk("rst_ready64", 64'(b64.in_ready), 64'd1);
        chk("rst_imm64", b64.out_imm, 64'd0);
        chk("rst_tag32", 64'(b32.out_tag), 64'd0);
        chk("rst_ill32", 64'(b32.out_illegal), 64'd0);

        // Hand-computed immediates.
        send1(32'hFFF00093, 3'd0, 32'h101);
        chk("I32", 64'(b32.out_imm), 64'hFFFF_FFFF);
        chk("I64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("I_ill", 64'(b32.out_illegal), 64'd0);
        send1(32'hFE112E23, 3'd1, 32'h102);
        chk("S32", 64'(b32.out_imm), 64'hFFFF_FFFC);
        send1(32'hFFDFF06F, 3'd3, 32'h103);
        chk("J32", 64'(b32.out_imm), 64'hFFFF_FFFC);
        chk("J_ill", 64'(b64.out_illegal), 64'd0);
        send1(32'h800000B7, 3'd4, 32'h104);
        chk("U64", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("U32", 64'(b32.out_imm), 64'h8000_0000);
        send1(32'h03F00013, 3'd6, 32'h105);
        chk("SH64", b64.out_imm, 64'h3F);
        chk("SH32", 64'(b32.out_imm), 64'h1F);
        send1(32'h000F8073, 3'd5, 32'h106);
        chk("Z64", b64.out_imm, 64'h1F);
        send1(32'hFFFFFFFF, 3'd7, 32'h107);
        chk("BAD_imm64", b64.out_imm, 64'd0);
        chk("BAD_ill32", 64'(b32.out_illegal), 64'd1);
        step();
        step();

        // Backpressure: stream tags 1..4 while the output is stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        nt = 1;
        for (int c = 0; c < 4; c++) begin
            in_tag   = 32'(nt);
            in_instr = $urandom;
            in_src   = 3'($urandom_range(0, 7));
            @(negedge clk);
            r = b32.in_ready;
            step();
            if (r) nt++;
        end
        @(negedge clk);
        chk("bp_accepted", 64'(nt), 64'd3);
        chk("bp_in_ready", 64'(b32.in_ready), 64'd0);
        chk("bp_head_tag", 64'(b32.out_tag), 64'd1);
        step();
        cap = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (nt < 5 && guard < 20) begin
            in_tag   = 32'(nt);
            in_instr = $urandom;
            in_src   = 3'($urandom_range(0, 7));
            @(negedge clk);
            r = b32.in_ready;
            step();
            if (r) nt++;
            guard++;
        end
        chk("bp_timeout", 64'(nt), 64'd5);
        in_valid = 1'b0;
        repeat (4) step();
        cap = 1'b0;
        chk("bp_count", 64'(emitted.size()), 64'd4);
        for (int i = 0; i < emitted.size() && i < 4; i++)
            chk("bp_order", 64'(emitted[i]), 64'(i + 1));

        // Flush while two entries are held, with a new entry offered the same cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 32'h11; step();
        in_tag    = 32'h12; step();
        flush     = 1'b1;
        in_tag    = 32'hDEAD; step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("fl_valid32", 64'(b32.out_valid), 64'd0);
        chk("fl_ready64", 64'(b64.in_ready), 64'd1);
        step();
        out_ready = 1'b1;
        repeat (4) step();
        chk("fl_dropped", 64'(saw_dead), 64'd0);

        // Reset while two entries are held and the output is stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 32'h21; step();
        in_tag    = 32'h22; step();
        in_valid  = 1'b0;
        rst       = 1'b1; step();
        rst       = 1'b0;
        @(negedge clk);
        chk("mr_valid64", 64'(b64.out_valid), 64'd0);
        chk("mr_ready32", 64'(b32.in_ready), 64'd1);
        chk("mr_imm32", 64'(b32.out_imm), 64'd0);
        chk("mr_tag64", 64'(b64.out_tag), 64'd0);
        chk("mr_ill64", 64'(b64.out_illegal), 64'd0);
        step();
        out_ready = 1'b1;
        repeat (4) step();

        // Random valid/ready/flush traffic.
        accepted = 0;
        guard = 0;
        while (accepted < 10000 && guard < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = $urandom;
            in_src    = 3'($urandom_range(0, 7));
            in_tag    = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 299) == 0);
            step();
            guard++;
        end
        chk("rand_budget", 64'(accepted >= 10000), 64'd1);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("drain_empty", 64'(b64.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Pipelined, parametrised immediate generator between decode and execute in the cached RV core. Supports XLEN 32/64 and adds CSR zimm and shift-amount immediates to the I/S/B/J/U set. Carries an opaque tag (PC/rd/etc.) alongside the immediate. Sits behind a valid/ready handshake with a 2-entry skid buffer and supports pipeline flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 (elaboration error otherwise)
TAG_W, 32, width of sideband tag carried with each immediate

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous kill of all buffered entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_instr  in  32  raw instruction word; bits [6:0] ignored
in_imm_src  in  3  immediate type, imm_src_e encoding
in_tag  in  TAG_W  sideband passed through unchanged
out_valid  out  1  out_imm/out_tag/out_illegal valid
out_ready  in  1  downstream accepts
out_imm  out  XLEN  extended immediate
out_tag  out  TAG_W  tag of the same entry
out_illegal  out  1  entry had an unsupported imm_src

Behaviour:
- Encoding (XLEN-wide, sign bit = instr[31] unless noted):
  - 000 I: sext(instr[31:20])
  - 001 S: sext({instr[31:25],instr[11:7]})
  - 010 B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - 011 J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
  - 100 U: sext({instr[31:12],12'b0}); upper 32 bits replicate instr[31] when XLEN=64
  - 101 Z: zext(instr[19:15])
  - 110 SH: zext(instr[24:20]) if XLEN=32; zext(instr[25:20]) if XLEN=64
  - 111: imm=0, out_illegal=1 (all other types: out_illegal=0)
- Handshake: transfer on valid&&ready at each side. Latency 1 cycle (accepted at edge N, visible on out_* after edge N). Full throughput when out_ready=1.
- in_ready = !skid_valid (registered; no combinational path from out_ready to in_ready).
- States by occupancy: EMPTY (out_valid=0), ONE (main full), TWO (main+skid full).
  - EMPTY: accept -> ONE.
  - ONE: accept & drain -> ONE (main reloaded); accept & !drain -> TWO (new entry into skid); drain only -> EMPTY.
  - TWO: in_ready=0; drain -> ONE (skid moves to main); else hold.
- Order strictly FIFO; out_* stable while out_valid && !out_ready.
- Reset: out_valid=0, out_imm=0, out_tag=0, out_illegal=0, skid cleared, in_ready=1 in the first cycle after reset deasserts. Reset mid-operation discards all entries; no partial outputs.
- flush: at the edge, both entries invalidated and any entry offered in the same cycle is dropped; out_valid=0, in_ready=1 next cycle. rst has priority over flush; flush has priority over accept/drain. Data registers need not be cleared on flush.
- Data regs load only on accept (no toggling while idle).

Decomposition:
- Package imm_pkg: imm_src_e enum (IMM_I..IMM_SH, IMM_BAD=3'b111), XLEN legality check constant.
- Sub-module imm_decode (combinational, parameter XLEN): in_instr/in_imm_src -> imm, illegal. imm_gen_stage instantiates it at the input, so buffers hold decoded values.

Test Plan:
- XLEN=32, I 0xFFF00093 -> 0xFFFFFFFF; S 0xFE112E23 -> 0xFFFFFFFC; J 0xFFDFF06F -> 0xFFFFFFFC; each 1 cycle after accept, out_illegal=0.
- XLEN=64, U 0x800000B7 -> 0xFFFFFFFF80000000; SH with instr[25:20]=6'h3F -> 0x3F (XLEN=32 same word -> 0x1F); Z with instr[19:15]=5'h1F -> 0x1F; src=111 -> imm 0, out_illegal=1.
- Backpressure: in_valid=1 streaming tags 1,2,3,4, out_ready=0 for 4 cycles -> exactly tags 1,2 accepted, in_ready=0 after second, out_* stable; out_ready=1 -> tags 1,2,3,4 emerge in order, no gaps or duplicates.
- Flush while TWO, with in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1; offered entry never appears at output.
- rst asserted for 1 cycle while TWO and out_ready=0 -> all outputs 0 and in_ready=1 after reset; no stale tag emerges later.
- Random valid/ready toggling 10k entries vs. scoreboard model: matching imm/tag/illegal order, no loss or duplication.
